// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// request payload and big-endian byte-lane select patterns.
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [LANES-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // sel[3] is the byte at offset 0 (wdata[31:24])
  localparam logic [LANES-1:0] SEL_B0 = 4'b1000;
  localparam logic [LANES-1:0] SEL_B1 = 4'b0100;
  localparam logic [LANES-1:0] SEL_B2 = 4'b0010;
  localparam logic [LANES-1:0] SEL_B3 = 4'b0001;
  localparam logic [LANES-1:0] SEL_HI = 4'b1100;
  localparam logic [LANES-1:0] SEL_LO = 4'b0011;
  localparam logic [LANES-1:0] SEL_W  = 4'b1111;

endpackage

// File: rtl/data_ram_bank.sv
// Single-port word RAM with per-byte write enables. The read port shows the
// post-write word when a write is presented (write-first).
module data_ram_bank
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [LANES-1:0]  sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rword_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] stored_c;
  logic [DATA_W-1:0] merged_c;

  // Lane merge: lane i of the word is wdata[8i+7:8i] when sel[i] is set
  always_comb begin
    stored_c = mem[addr];
    merged_c = stored_c;
    for (int i = 0; i < int'(LANES); i++) begin
      if (sel[i]) begin
        merged_c[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    rword_c = we ? merged_c : stored_c;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= merged_c;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// MEM-stage data port responder: captures a request, inserts programmable
// wait states while stalling the pipeline, then returns a one-cycle response.
module data_sram_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [LANES-1:0]  sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              valid_o,
  output logic              err_o,
  output logic              stall_o
);

  // Counter holds the wait cycles remaining after the current one, so the
  // response lands exactly WAIT_CYCLES+1 cycles after the request.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  req_t              acc;
  logic              access_c;
  logic              oor_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              unused_lsb;

  // Live inputs in IDLE (zero-wait access), captured request otherwise
  always_comb begin
    if (state_q == IDLE) begin
      acc.we    = we_i;
      acc.addr  = addr_i;
      acc.sel   = sel_i;
      acc.wdata = wdata_i;
    end else begin
      acc = req_q;
    end
  end

  assign oor_c      = |acc.addr[DATA_W-1:ADDR_W+2];
  assign ram_we_c   = access_c & acc.we & ~oor_c;
  assign unused_lsb = ^acc.addr[1:0];

  data_ram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .addr    (acc.addr[ADDR_W+1:2]),
    .we      (ram_we_c),
    .sel     (acc.sel),
    .wdata   (acc.wdata),
    .rword_c (ram_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Request payload needs no reset; it is only used after a capture
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    access_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_i) begin
          req_d = acc;
          cnt_d = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            access_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          access_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = access_c;
    err_d   = access_c & oor_c;
    rdata_d = rdata_q;
    if (access_c) begin
      rdata_d = oor_c ? '0 : ram_word;
    end
  end

  assign stall_o = ((state_q == IDLE) && ce_i) || (state_q == WAIT);
  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance with two wait states,
// one with zero wait states.
module tb_data_sram_responder;
  import data_mem_pkg::*;

  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ce2, we2, valid2, err2, stall2;
  logic [31:0] addr2, wdata2, rdata2;
  logic [3:0]  sel2;
  logic        ce0, we0, valid0, err0, stall0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  sel0;

  data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .ce_i(ce2), .we_i(we2), .addr_i(addr2),
    .sel_i(sel2), .wdata_i(wdata2), .rdata_o(rdata2), .valid_o(valid2),
    .err_o(err2), .stall_o(stall2)
  );

  data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0),
    .sel_i(sel0), .wdata_i(wdata0), .rdata_o(rdata0), .valid_o(valid0),
    .err_o(err0), .stall_o(stall0)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the two-wait-state instance; checks stall and latency
  task automatic req2(input logic we, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rdv, output logic erv);
    int lat;
    lat = 0;
    ce2 = 1'b1; we2 = we; addr2 = a; sel2 = s; wdata2 = wd;
    #1;
    chk("stall_cycle0", 32'(stall2), 32'd1);
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (valid2) lat = n;
      else chk("stall_wait", 32'(stall2), 32'd1);
    end
    chk("latency", 32'(lat), 32'd3);
    chk("stall_resp", 32'(stall2), 32'd0);
    rdv = rdata2;
    erv = err2;
    ce2 = 1'b0;
    @(posedge clk); #1;
    chk("valid_single", 32'(valid2), 32'd0);
    chk("err_idle", 32'(err2), 32'd0);
  endtask

  task automatic write0(input logic [31:0] a, input logic [31:0] wd);
    ce0 = 1'b1; we0 = 1'b1; addr0 = a; sel0 = SEL_W; wdata0 = wd;
    #1;
    chk("w0_stall", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    chk("w0_valid", 32'(valid0), 32'd1);
    chk("w0_rdata", rdata0, wd);
    ce0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ce2 = 1'b0; we2 = 1'b0; addr2 = '0; sel2 = '0; wdata2 = '0;
    ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_rdata", rdata2, 32'h0);
    chk("rst_valid", 32'(valid2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_stall", 32'(stall2), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    @(posedge clk); #1;

    // Full word write then read
    req2(1'b1, 32'h10, SEL_W, 32'hDEADBEEF, rd, er);
    chk("wr_full_rdata", rd, 32'hDEADBEEF);
    req2(1'b0, 32'h10, SEL_W, 32'h0, rd, er);
    chk("rd_full", rd, 32'hDEADBEEF);
    chk("rd_full_err", 32'(er), 32'd0);

    // Single byte lane at offset 1
    req2(1'b1, 32'h11, SEL_B1, 32'h55555555, rd, er);
    chk("wr_byte_rdata", rd, 32'hDE55BEEF);
    req2(1'b0, 32'h10, SEL_W, 32'h0, rd, er);
    chk("rd_byte", rd, 32'hDE55BEEF);

    // Low half, then an empty-lane write
    req2(1'b1, 32'h12, SEL_LO, 32'h12341234, rd, er);
    chk("wr_half_rdata", rd, 32'hDE551234);
    req2(1'b1, 32'h12, 4'b0000, 32'hFFFFFFFF, rd, er);
    chk("wr_nosel_rdata", rd, 32'hDE551234);
    chk("wr_nosel_err", 32'(er), 32'd0);
    req2(1'b0, 32'h10, SEL_W, 32'h0, rd, er);
    chk("rd_half", rd, 32'hDE551234);
    chk("rdata_hold", rdata2, 32'hDE551234);

    // Out of range read and write (write would alias word 4)
    req2(1'b0, 32'h0001_0000, SEL_W, 32'h0, rd, er);
    chk("oor_rd_rdata", rd, 32'h0);
    chk("oor_rd_err", 32'(er), 32'd1);
    req2(1'b1, 32'h0001_0010, SEL_W, 32'hFFFFFFFF, rd, er);
    chk("oor_wr_rdata", rd, 32'h0);
    chk("oor_wr_err", 32'(er), 32'd1);
    req2(1'b0, 32'h10, SEL_W, 32'h0, rd, er);
    chk("oor_ram_intact", rd, 32'hDE551234);

    // Reset in the middle of a write drops it
    req2(1'b1, 32'h20, SEL_W, 32'h11223344, rd, er);
    ce2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; sel2 = SEL_W; wdata2 = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("abort_in_wait", 32'(stall2), 32'd1);
    rst = 1'b1;
    ce2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall2), 32'd0);
    chk("abort_rdata", rdata2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_valid", 32'(valid2), 32'd0);
      @(posedge clk); #1;
    end
    req2(1'b0, 32'h20, SEL_W, 32'h0, rd, er);
    chk("abort_ram_prior", rd, 32'h11223344);

    // Zero wait states: back-to-back reads
    write0(32'h10, 32'hA5A5A5A5);
    write0(32'h14, 32'h5A5A5A5A);
    ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; sel0 = SEL_W;
    #1;
    chk("b2b_c0_stall", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    chk("b2b_c1_valid", 32'(valid0), 32'd1);
    chk("b2b_c1_rdata", rdata0, 32'hA5A5A5A5);
    chk("b2b_c1_stall", 32'(stall0), 32'd0);
    addr0 = 32'h14;
    @(posedge clk); #1;
    chk("b2b_c2_valid", 32'(valid0), 32'd0);
    chk("b2b_c2_stall", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    chk("b2b_c3_valid", 32'(valid0), 32'd1);
    chk("b2b_c3_rdata", rdata0, 32'h5A5A5A5A);
    chk("b2b_c3_stall", 32'(stall0), 32'd0);
    ce0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_c4_valid", 32'(valid0), 32'd0);
    chk("b2b_c4_rdata_hold", rdata0, 32'h5A5A5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
